// File: rtl/mem_port_sequencer.sv
// ---------------------------------------------------------------------------
// mem_port_sequencer
//   Request sequencer for one port of the dual-port memory sub_system.
//   A valid/ready request is latched into the port pins (en/we/add/din) and
//   held for exactly WL (write) or RL (read) clocks. For reads, the memory
//   output is captured on the last read cycle and returned as a one-cycle
//   response pulse. Completed writes and reads are counted (wrapping).
//
// Ports
//   input_clk    in   1      clock, rising edge
//   input_rst    in   1      synchronous active-high reset
//   req_valid    in   1      request present
//   req_ready    out  1      sequencer idle and able to accept
//   req_we       in   1      1 = write, 0 = read
//   req_addr     in   A_W    request address
//   req_data     in   D_W    write data (ignored for reads)
//   mem_en       out  1      port enable to sub_system
//   mem_we       out  1      port write enable to sub_system
//   mem_add      out  A_W    port address to sub_system
//   mem_din      out  D_W    port write data to sub_system
//   mem_dout     in   D_W    port read data from sub_system
//   rsp_valid    out  1      one-cycle read response pulse
//   rsp_addr     out  A_W    address of the completed read
//   rsp_data     out  D_W    captured read data
//   wr_done_cnt  out  CNT_W  completed writes (wraps)
//   rd_done_cnt  out  CNT_W  completed reads (wraps)
// ---------------------------------------------------------------------------
module mem_port_sequencer #(
  parameter int unsigned D_W   = 8,
  parameter int unsigned A_W   = 6,
  parameter int unsigned WL    = 3,
  parameter int unsigned RL    = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             input_clk,
  input  logic             input_rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [A_W-1:0]   req_addr,
  input  logic [D_W-1:0]   req_data,
  output logic             mem_en,
  output logic             mem_we,
  output logic [A_W-1:0]   mem_add,
  output logic [D_W-1:0]   mem_din,
  input  logic [D_W-1:0]   mem_dout,
  output logic             rsp_valid,
  output logic [A_W-1:0]   rsp_addr,
  output logic [D_W-1:0]   rsp_data,
  output logic [CNT_W-1:0] wr_done_cnt,
  output logic [CNT_W-1:0] rd_done_cnt
);

  // Latency counter only needs to reach max(WL,RL)-1.
  localparam int unsigned LAT_MAX = (WL > RL) ? WL : RL;
  localparam int unsigned LAT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  localparam logic [LAT_W-1:0] WL_LAST = LAT_W'(WL - 1);
  localparam logic [LAT_W-1:0] RL_LAST = LAT_W'(RL - 1);

  // Zero latency would leave the port enable asserted for no cycle at all.
  if (WL < 1) begin : g_wl_chk
    $error("mem_port_sequencer: WL must be >= 1");
  end
  if (RL < 1) begin : g_rl_chk
    $error("mem_port_sequencer: RL must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2
  } state_e;

  state_e           state_q,     state_d;
  logic [LAT_W-1:0] lat_q,       lat_d;
  logic             ready_q,     ready_d;
  logic             en_q,        en_d;
  logic             we_q,        we_d;
  logic [A_W-1:0]   add_q,       add_d;
  logic [D_W-1:0]   din_q,       din_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [A_W-1:0]   rsp_addr_q,  rsp_addr_d;
  logic [D_W-1:0]   rsp_data_q,  rsp_data_d;
  logic [CNT_W-1:0] wr_cnt_q,    wr_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q,    rd_cnt_d;

  // State and output registers; reset clears everything including req_ready.
  always_ff @(posedge input_clk) begin
    if (input_rst) begin
      state_q     <= S_IDLE;
      lat_q       <= '0;
      ready_q     <= 1'b0;
      en_q        <= 1'b0;
      we_q        <= 1'b0;
      add_q       <= '0;
      din_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      ready_q     <= ready_d;
      en_q        <= en_d;
      we_q        <= we_d;
      add_q       <= add_d;
      din_q       <= din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_data_q  <= rsp_data_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
    end
  end

  // Next-state logic. Registered outputs are computed from the next state so
  // en/we/ready line up with the state they describe.
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    ready_d     = 1'b0;
    en_d        = 1'b0;
    we_d        = 1'b0;
    add_d       = add_q;
    din_d       = din_q;
    rsp_valid_d = 1'b0;
    rsp_addr_d  = rsp_addr_q;
    rsp_data_d  = rsp_data_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          add_d = req_addr;
          lat_d = '0;
          en_d  = 1'b1;
          if (req_we) begin
            state_d = S_WRITE;
            din_d   = req_data;
            we_d    = 1'b1;
          end else begin
            state_d = S_READ;
          end
        end else begin
          ready_d = 1'b1;
        end
      end

      S_WRITE: begin
        if (lat_q == WL_LAST) begin
          state_d  = S_IDLE;
          lat_d    = '0;
          ready_d  = 1'b1;
          wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end else begin
          lat_d = lat_q + LAT_W'(1);
          en_d  = 1'b1;
          we_d  = 1'b1;
        end
      end

      S_READ: begin
        if (lat_q == RL_LAST) begin
          // Last read cycle: memory data is valid now.
          state_d     = S_IDLE;
          lat_d       = '0;
          ready_d     = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_addr_d  = add_q;
          rsp_data_d  = mem_dout;
          rd_cnt_d    = rd_cnt_q + CNT_W'(1);
        end else begin
          lat_d = lat_q + LAT_W'(1);
          en_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        lat_d   = '0;
        ready_d = 1'b1;
      end
    endcase
  end

  assign req_ready   = ready_q;
  assign mem_en      = en_q;
  assign mem_we      = we_q;
  assign mem_add     = add_q;
  assign mem_din     = din_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_addr    = rsp_addr_q;
  assign rsp_data    = rsp_data_q;
  assign wr_done_cnt = wr_cnt_q;
  assign rd_done_cnt = rd_cnt_q;

endmodule
